// File: rtl/seq_det_pkg.sv
// Shared defaults and helpers for the parametrised serial sequence detector.
// The default pattern is stored MSB-first, i.e. bit PAT_LEN-1 is received first.
package seq_det_pkg;
    localparam int         SEQ_DET_PAT_LEN_DEF = 4;
    localparam int         SEQ_DET_CNT_W_DEF   = 8;
    localparam logic [3:0] SEQ_DET_DEFAULT_PAT = 4'b1011;

    // The fill counter has to hold every value from 0 up to and including PAT_LEN.
    function automatic int seq_det_fill_w(input int pat_len);
        return $clog2(pat_len + 1);
    endfunction
endpackage

// File: rtl/seq_det_cnt.sv
// Saturating match counter with a sticky saturation flag.
// A clear that lands in the same cycle as an increment leaves the count at 1.
module seq_det_cnt
    import seq_det_pkg::*;
#(
    parameter int CNT_W = SEQ_DET_CNT_W_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    input  logic             clear,
    output logic [CNT_W-1:0] count,
    output logic             sat
);
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
            sat   <= 1'b0;
        end else if (clear) begin
            count <= inc ? CNT_W'(1) : '0;
            sat   <= 1'b0;
        end else if (inc) begin
            // Hold at all-ones and remember that a match was lost.
            if (&count) sat <= 1'b1;
            else        count <= count + CNT_W'(1);
        end
    end
endmodule

// File: rtl/seq_det_param.sv
// Serial pattern detector with a runtime-loadable PAT_LEN-bit pattern.
// Overlap mode is selectable per cycle; matches feed a saturating counter.
module seq_det_param
    import seq_det_pkg::*;
#(
    parameter int                 PAT_LEN     = SEQ_DET_PAT_LEN_DEF,
    parameter int                 CNT_W       = SEQ_DET_CNT_W_DEF,
    parameter logic [PAT_LEN-1:0] DEFAULT_PAT = PAT_LEN'(SEQ_DET_DEFAULT_PAT)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               din_valid,
    input  logic               din,
    input  logic               pat_load,
    input  logic [PAT_LEN-1:0] pat_in,
    input  logic               overlap,
    input  logic               clear,
    output logic               dout,
    output logic [CNT_W-1:0]   match_count,
    output logic               count_sat
);
    localparam int FILL_W = seq_det_fill_w(PAT_LEN);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN);

    logic [PAT_LEN-1:0] pattern;
    logic [PAT_LEN-1:0] history;
    logic [FILL_W-1:0]  fill;

    logic [PAT_LEN-1:0] hist_n;
    logic [FILL_W-1:0]  fill_n;
    logic               match;

    always_comb begin
        hist_n = {history[PAT_LEN-2:0], din};
        fill_n = (fill == FILL_FULL) ? FILL_FULL : fill + FILL_W'(1);
        // A load wins over data, so a bit arriving with pat_load never matches.
        match  = din_valid && !pat_load && (fill_n == FILL_FULL) && (hist_n == pattern);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pattern <= DEFAULT_PAT;
            history <= '0;
            fill    <= '0;
            dout    <= 1'b0;
        end else begin
            dout <= match;
            if (pat_load) begin
                pattern <= pat_in;
                history <= '0;
                fill    <= '0;
            end else if (din_valid) begin
                history <= hist_n;
                // Non-overlap: restart the fill so the next match needs PAT_LEN fresh bits.
                fill    <= (match && !overlap) ? '0 : fill_n;
            end
        end
    end

    seq_det_cnt #(.CNT_W(CNT_W)) u_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (match),
        .clear (clear),
        .count (match_count),
        .sat   (count_sat)
    );
endmodule

// File: tb/tb_seq_det_param.sv
// Bench for seq_det_param: directed scenarios plus random traffic against a queue-based model.
// Two DUTs share stimulus; the narrow-counter copy exercises saturation.
module tb_seq_det_param;
    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       din_valid = 1'b0, din = 1'b0, pat_load = 1'b0, overlap = 1'b0, clear = 1'b0;
    logic [3:0] pat_in = 4'h0;

    logic       d8, s8, d2, s2;
    logic [7:0] c8;
    logic [1:0] c2;

    int n_vec = 0;
    int n_err = 0;
    bit chk_on = 1'b0;

    always #5 clock = ~clock;

    seq_det_param #(.PAT_LEN(4), .CNT_W(8)) dut8 (
        .clock(clock), .reset(reset), .din_valid(din_valid), .din(din),
        .pat_load(pat_load), .pat_in(pat_in), .overlap(overlap), .clear(clear),
        .dout(d8), .match_count(c8), .count_sat(s8));

    seq_det_param #(.PAT_LEN(4), .CNT_W(2)) dut2 (
        .clock(clock), .reset(reset), .din_valid(din_valid), .din(din),
        .pat_load(pat_load), .pat_in(pat_in), .overlap(overlap), .clear(clear),
        .dout(d2), .match_count(c2), .count_sat(s2));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the valid bits seen since the last reset/load/non-overlap restart.
    bit   q[$];
    logic [3:0] m_pat;
    logic m_dout, m_sat8, m_sat2;
    int   m_cnt8, m_cnt2;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_pat = 4'b1011; q.delete(); m_dout = 0;
            m_cnt8 = 0; m_sat8 = 0; m_cnt2 = 0; m_sat2 = 0;
        end else begin
            bit   hit;
            logic [3:0] h;
            hit = 0;
            if (pat_load) begin
                m_pat = pat_in; q.delete();
            end else if (din_valid) begin
                q.push_back(din);
                if (q.size() > 4) void'(q.pop_front());
                h = '0;
                foreach (q[i]) h = {h[2:0], q[i]};
                hit = (q.size() == 4) && (h == m_pat);
                if (hit && !overlap) q.delete();
            end
            m_dout = hit;
            if (clear) begin
                m_cnt8 = hit ? 1 : 0; m_sat8 = 0;
                m_cnt2 = hit ? 1 : 0; m_sat2 = 0;
            end else if (hit) begin
                if (m_cnt8 == 255) m_sat8 = 1; else m_cnt8++;
                if (m_cnt2 == 3)   m_sat2 = 1; else m_cnt2++;
            end
        end
    end

    always @(negedge clock) begin
        if (chk_on) begin
            chk("dout8", d8, m_dout);
            chk("cnt8",  c8, m_cnt8);
            chk("sat8",  s8, m_sat8);
            chk("dout2", d2, m_dout);
            chk("cnt2",  c2, m_cnt2);
            chk("sat2",  s2, m_sat2);
        end
    end

    task automatic cyc(input logic v, input logic b, input logic ld, input logic [3:0] p,
                       input logic cl, output logic d);
        @(negedge clock); #1;
        din_valid = v; din = b; pat_load = ld; pat_in = p; clear = cl;
        @(posedge clock); #1;
        d = d8;
    endtask

    // Apply n cycles, MSB-first, with per-cycle valid; return the dout seen after each edge.
    task automatic seq(input int n, input logic [15:0] v, input logic [15:0] b,
                       output logic [15:0] pulses);
        logic d;
        pulses = '0;
        for (int i = n - 1; i >= 0; i--) begin
            cyc(v[i], b[i], 1'b0, 4'h0, 1'b0, d);
            pulses[i] = d;
        end
    endtask

    initial begin
        logic [15:0] pm;
        logic d;

        // Reset held for two cycles.
        repeat (2) @(posedge clock);
        @(negedge clock); #1;
        reset = 1'b1;
        chk_on = 1'b1;
        #1;
        chk("rst_dout", d8, 0);
        chk("rst_cnt",  c8, 0);
        chk("rst_sat",  s8, 0);

        // Default pattern, no load.
        seq(4, 16'hF, 16'b1011, pm);
        chk("default_pulses", pm[3:0], 4'b0001);
        chk("default_cnt", c8, 1);

        // Overlap on 1011011.
        overlap = 1'b1;
        cyc(0, 0, 1, 4'b1011, 1, d);
        seq(7, 16'h7F, 16'b1011011, pm);
        chk("ovl_pulses", pm[6:0], 7'b0001001);
        chk("ovl_cnt", c8, 2);

        // Non-overlap on the same stream.
        overlap = 1'b0;
        cyc(0, 0, 1, 4'b1011, 1, d);
        seq(7, 16'h7F, 16'b1011011, pm);
        chk("novl_pulses", pm[6:0], 7'b0001000);
        chk("novl_cnt", c8, 1);

        // Load 0110 after partial bits, then feed it with gaps.
        seq(2, 16'b11, 16'b10, pm);
        cyc(0, 0, 1, 4'b0110, 0, d);
        seq(7, 16'b1010101, 16'b0010100, pm);
        chk("gap_pulses", pm[6:0], 7'b0000001);

        // Saturation on the 2-bit counter.
        cyc(0, 0, 1, 4'b1011, 1, d);
        seq(16, 16'hFFFF, 16'hBBBB, pm);
        chk("sat_cnt2", c2, 3);
        chk("sat_flag2", s2, 1);
        chk("sat_cnt8", c8, 4);
        cyc(0, 0, 0, 4'h0, 1, d);
        chk("clr_cnt2", c2, 0);
        chk("clr_sat2", s2, 0);
        seq(3, 16'h7, 16'b101, pm);
        cyc(1, 1, 0, 4'h0, 1, d);
        chk("clr_match_dout", d, 1);
        chk("clr_match_cnt2", c2, 1);
        chk("clr_match_cnt8", c8, 1);

        // Asynchronous reset mid-pattern after loading a different pattern.
        cyc(0, 0, 1, 4'b0110, 0, d);
        seq(3, 16'h7, 16'b101, pm);
        @(negedge clock); #2;
        reset = 1'b0;
        #1;
        chk("arst_dout", d8, 0);
        chk("arst_cnt8", c8, 0);
        chk("arst_cnt2", c2, 0);
        chk("arst_sat8", s8, 0);
        din_valid = 1'b0; pat_load = 1'b0; clear = 1'b0;
        @(posedge clock);
        @(negedge clock); #1;
        reset = 1'b1;
        seq(4, 16'hF, 16'b1011, pm);
        chk("arst_default_pulses", pm[3:0], 4'b0001);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) overlap = ~overlap;
            cyc($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 60) == 0,
                4'($urandom), $urandom_range(0, 40) == 0, d);
        end
        cyc(0, 0, 0, 4'h0, 0, d);
        @(negedge clock); #1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, limit %0t", $time);
        $fatal(1);
    end
endmodule
